// File: rtl/dna_reader.sv
// dna_reader: reads a device DNA identifier out of a DNA_PORT-style serial
// primitive and presents it as a parallel word. The primitive clock and the
// READ/SHIFT strobes are generated from the fabric clock. Bits are captured
// MSB first. The captured word can optionally be compared with a build-time
// constant.
//
// Ports:
//   clk        fabric clock
//   rst        asynchronous active-high reset
//   start      read request pulse (ignored while busy or finishing)
//   busy       read in progress
//   done       one-cycle pulse when dna_out becomes valid
//   dna_valid  dna_out holds a complete read
//   dna_out    captured identifier, MSB = first bit shifted out
//   match      dna_out == EXPECTED_DNA (only when CHECK_EN); valid with dna_valid
//   dna_clk    primitive CLK (registered)
//   dna_read   primitive READ
//   dna_shift  primitive SHIFT
//   dna_din    primitive DIN, tied low
//   dna_dout   primitive DOUT
module dna_reader #(
  parameter int unsigned          DNA_WIDTH    = 57,
  parameter int unsigned          CLK_DIV      = 2,
  parameter bit                   AUTO_START   = 1'b1,
  parameter bit                   CHECK_EN     = 1'b0,
  parameter logic [DNA_WIDTH-1:0] EXPECTED_DNA = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 dna_valid,
  output logic [DNA_WIDTH-1:0] dna_out,
  output logic                 match,
  output logic                 dna_clk,
  output logic                 dna_read,
  output logic                 dna_shift,
  output logic                 dna_din,
  input  logic                 dna_dout
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DNA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StFinish} state_t;

  state_t               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DNA_WIDTH-1:0] shift_q;
  logic                 first_q;  // high only on the first cycle after reset
  logic                 tick;

  assign dna_din = 1'b0;
  assign tick    = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      first_q   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      dna_valid <= 1'b0;
      dna_out   <= '0;
      match     <= 1'b0;
      dna_clk   <= 1'b0;
      dna_read  <= 1'b0;
      dna_shift <= 1'b0;
    end else begin
      first_q <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          div_q   <= '0;
          dna_clk <= 1'b0;
          if (start || (AUTO_START && first_q)) begin
            state_q   <= StLoad;
            dna_read  <= 1'b1;
            busy      <= 1'b1;
            dna_valid <= 1'b0;
            match     <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
          end
        end
        StLoad: begin
          if (tick) begin
            div_q   <= '0;
            dna_clk <= ~dna_clk;
            // The first rise loads the primitive; switch to shifting on the
            // following fall so READ/SHIFT get a half-period of setup.
            if (dna_clk) begin
              dna_read  <= 1'b0;
              dna_shift <= 1'b1;
              state_q   <= StShift;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        StShift: begin
          if (tick) begin
            div_q   <= '0;
            dna_clk <= ~dna_clk;
            // Sample DOUT on the edge that raises dna_clk; the primitive
            // presents the next bit only after that rise.
            if (!dna_clk) begin
              shift_q <= {shift_q[DNA_WIDTH-2:0], dna_dout};
              cnt_q   <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_LAST) begin
                state_q <= StFinish;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        StFinish: begin
          div_q     <= '0;
          dna_clk   <= 1'b0;
          dna_shift <= 1'b0;
          busy      <= 1'b0;
          dna_out   <= shift_q;
          dna_valid <= 1'b1;
          done      <= 1'b1;
          match     <= CHECK_EN && (shift_q == EXPECTED_DNA);
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_reader.sv
module tb_dna_reader;
  localparam int unsigned WA = 57;
  localparam int unsigned DA = 2;
  localparam int unsigned WB = 8;
  localparam int unsigned DB = 1;
  localparam logic [WA-1:0] EXP_A = 57'h1A2B3C4D5E6F789;
  localparam int DONE_A = int'(DA * (2 * WA + 1) + 1);
  localparam int DONE_B = int'(DB * (2 * WB + 1) + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, busy_a, done_a, valid_a, match_a, dclk_a, read_a, shift_a, din_a, dout_a;
  logic [WA-1:0] out_a, val_a;
  logic rst_b, start_b, busy_b, done_b, valid_b, match_b, dclk_b, read_b, shift_b, din_b, dout_b;
  logic [WB-1:0] out_b, val_b;

  int errors = 0;
  int checks = 0;

  dna_reader #(.DNA_WIDTH(WA), .CLK_DIV(DA), .AUTO_START(1'b1), .CHECK_EN(1'b1),
               .EXPECTED_DNA(EXP_A)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .dna_valid(valid_a), .dna_out(out_a), .match(match_a), .dna_clk(dclk_a),
    .dna_read(read_a), .dna_shift(shift_a), .dna_din(din_a), .dna_dout(dout_a));

  dna_reader #(.DNA_WIDTH(WB), .CLK_DIV(DB), .AUTO_START(1'b0), .CHECK_EN(1'b0),
               .EXPECTED_DNA(8'h00)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .dna_valid(valid_b), .dna_out(out_b), .match(match_b), .dna_clk(dclk_b),
    .dna_read(read_b), .dna_shift(shift_b), .dna_din(din_b), .dna_dout(dout_b));

  // Behavioural DNA primitives: READ on a rise points at the MSB, SHIFT on a
  // rise moves to the next lower bit; DOUT shows the pointed-at bit.
  int idx_a = -1;
  int idx_b = -1;
  always @(posedge dclk_a) begin
    if (read_a) idx_a <= int'(WA) - 1;
    else if (shift_a) idx_a <= idx_a - 1;
  end
  always @(posedge dclk_b) begin
    if (read_b) idx_b <= int'(WB) - 1;
    else if (shift_b) idx_b <= idx_b - 1;
  end
  assign dout_a = (idx_a >= 0) ? val_a[idx_a[5:0]] : 1'b0;
  assign dout_b = (idx_b >= 0) ? val_b[idx_b[2:0]] : 1'b0;

  // Observation results (filled by the watch tasks, compared by the tests)
  int w_done_cyc, w_ndone, w_rises, w_rise_err, w_busy_err, w_strobe_err;

  task automatic watch_a(input int ncyc, input bit pulses);
    logic prev;
    w_done_cyc = -1; w_ndone = 0; w_rises = 0;
    w_rise_err = 0; w_busy_err = 0; w_strobe_err = 0;
    prev = dclk_a;
    for (int n = 0; n < ncyc; n++) begin
      start_a = pulses && n > 0 && ((n % 10 == 0 && n < DONE_A) || n == DONE_A);
      @(posedge clk); #1;
      start_a = 1'b0;
      if (dclk_a && !prev) begin
        if (n != int'(DA) * (2 * w_rises + 1)) w_rise_err++;
        w_rises++;
      end
      prev = dclk_a;
      if (done_a) begin w_ndone++; w_done_cyc = n; end
      if (busy_a !== (n < DONE_A)) w_busy_err++;
      if (read_a !== (n < 2 * int'(DA)) || shift_a !== (n >= 2 * int'(DA) && n < DONE_A))
        w_strobe_err++;
    end
  endtask

  task automatic watch_b(input int ncyc);
    logic prev;
    w_done_cyc = -1; w_ndone = 0; w_rises = 0;
    w_rise_err = 0; w_busy_err = 0; w_strobe_err = 0;
    prev = dclk_b;
    for (int n = 0; n < ncyc; n++) begin
      start_b = (n == 0);
      @(posedge clk); #1;
      start_b = 1'b0;
      if (dclk_b && !prev) begin
        if (n != int'(DB) * (2 * w_rises + 1)) w_rise_err++;
        w_rises++;
      end
      prev = dclk_b;
      if (done_b) begin w_ndone++; w_done_cyc = n; end
      if (busy_b !== (n < DONE_B)) w_busy_err++;
      if (read_b !== (n < 2 * int'(DB)) || shift_b !== (n >= 2 * int'(DB) && n < DONE_B))
        w_strobe_err++;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, done_a, valid_a, match_a, dclk_a, read_a, shift_a, din_a} !== 8'h00
        || out_a !== '0) begin
      errors++;
      $display("FAIL reset_a: got ctl=%b out=%h want all zero",
               {busy_a, done_a, valid_a, match_a, dclk_a, read_a, shift_a, din_a}, out_a);
    end
    checks++;
    if ({busy_b, done_b, valid_b, match_b, dclk_b, read_b, shift_b, din_b} !== 8'h00
        || out_b !== '0) begin
      errors++;
      $display("FAIL reset_b: got ctl=%b out=%h want all zero",
               {busy_b, done_b, valid_b, match_b, dclk_b, read_b, shift_b, din_b}, out_b);
    end
  endtask

  task automatic test_auto_read(input logic [WA-1:0] val, input bit pulses, input string name);
    logic exp_match;
    exp_match = (val == EXP_A);
    rst_a = 1'b1;
    val_a = val;
    @(negedge clk);
    rst_a = 1'b0;
    watch_a(DONE_A + 20, pulses);
    checks++;
    if (w_done_cyc != DONE_A) begin
      errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, w_done_cyc, DONE_A);
    end
    checks++;
    if (w_ndone != 1) begin
      errors++; $display("FAIL %s done_count: got %0d want 1", name, w_ndone);
    end
    checks++;
    if (w_rises != int'(WA) + 1 || w_rise_err != 0) begin
      errors++;
      $display("FAIL %s dna_clk_rises: got %0d (misplaced %0d) want %0d (misplaced 0)",
               name, w_rises, w_rise_err, WA + 1);
    end
    checks++;
    if (w_busy_err != 0) begin
      errors++; $display("FAIL %s busy_shape: got %0d bad cycles want 0", name, w_busy_err);
    end
    checks++;
    if (w_strobe_err != 0) begin
      errors++; $display("FAIL %s read_shift: got %0d bad cycles want 0", name, w_strobe_err);
    end
    checks++;
    if (out_a !== val || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL %s dna_out: got %h valid=%b want %h valid=1", name, out_a, valid_a, val);
    end
    checks++;
    if (match_a !== exp_match) begin
      errors++; $display("FAIL %s match: got %b want %b", name, match_a, exp_match);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    logic [WA-1:0] val;
    logic prev;
    int rises, ndone, n;
    bit hit;
    r = {$urandom, $urandom};
    val = r[WA-1:0];
    rst_a = 1'b1;
    val_a = val;
    @(negedge clk);
    rst_a = 1'b0;
    prev = 1'b0; rises = 0; ndone = 0; hit = 1'b0; n = 0;
    while (!hit && n < DONE_A) begin
      @(posedge clk); #1;
      if (dclk_a && !prev) rises++;
      prev = dclk_a;
      if (done_a) ndone++;
      if (rises == 21) hit = 1'b1;  // load edge plus 20 captures
      n++;
    end
    checks++;
    if (!hit || ndone != 0) begin
      errors++; $display("FAIL mid_reach: got reached=%b done=%0d want reached=1 done=0",
                         hit, ndone);
    end
    rst_a = 1'b1;
    #1;
    checks++;
    if ({busy_a, done_a, valid_a, match_a, dclk_a, read_a, shift_a, din_a} !== 8'h00
        || out_a !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ctl=%b out=%h want all zero",
               {busy_a, done_a, valid_a, match_a, dclk_a, read_a, shift_a, din_a}, out_a);
    end
    @(negedge clk);
    rst_a = 1'b0;
    watch_a(DONE_A + 10, 1'b0);
    checks++;
    if (w_ndone != 1 || w_done_cyc != DONE_A) begin
      errors++; $display("FAIL mid_restart_done: got count=%0d cycle=%0d want 1 at %0d",
                         w_ndone, w_done_cyc, DONE_A);
    end
    checks++;
    if (out_a !== val) begin
      errors++; $display("FAIL mid_restart_value: got %h want %h", out_a, val);
    end
  endtask

  task automatic test_idle_no_auto();
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy_b !== 1'b0 || read_b !== 1'b0 || dclk_b !== 1'b0) begin
      errors++; $display("FAIL no_auto_idle: got busy=%b read=%b dclk=%b want 0 0 0",
                         busy_b, read_b, dclk_b);
    end
    @(negedge clk);
  endtask

  task automatic test_small_read(input logic [WB-1:0] val);
    val_b = val;
    watch_b(DONE_B + 4);
    checks++;
    if (w_done_cyc != DONE_B || w_ndone != 1) begin
      errors++; $display("FAIL small_done: got count=%0d cycle=%0d want 1 at %0d",
                         w_ndone, w_done_cyc, DONE_B);
    end
    checks++;
    if (w_rises != int'(WB) + 1 || w_rise_err != 0) begin
      errors++; $display("FAIL small_captures: got rises=%0d misplaced=%0d want %0d and 0",
                         w_rises, w_rise_err, WB + 1);
    end
    checks++;
    if (w_busy_err != 0 || w_strobe_err != 0) begin
      errors++; $display("FAIL small_strobes: got busy_bad=%0d strobe_bad=%0d want 0 0",
                         w_busy_err, w_strobe_err);
    end
    checks++;
    if (out_b !== val || valid_b !== 1'b1 || match_b !== 1'b0) begin
      errors++; $display("FAIL small_value: got %h valid=%b match=%b want %h valid=1 match=0",
                         out_b, valid_b, match_b, val);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [WB-1:0] v1, v2, v3;
    int n, dcyc, hold_err;
    r = $urandom;
    v1 = r[7:0]; v2 = ~v1; v3 = r[15:8];
    test_small_read(v1);
    // Re-read while dna_valid is high
    val_b = v2;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    checks++;
    if (valid_b !== 1'b0 || busy_b !== 1'b1 || out_b !== v1) begin
      errors++; $display("FAIL reread_accept: got valid=%b busy=%b out=%h want 0 1 %h",
                         valid_b, busy_b, out_b, v1);
    end
    n = 0; dcyc = -1; hold_err = 0;
    while (dcyc < 0 && n < DONE_B + 4) begin
      @(posedge clk); #1;
      n++;
      if (done_b) dcyc = n;
      else if (out_b !== v1) hold_err++;
    end
    checks++;
    if (dcyc != DONE_B || hold_err != 0) begin
      errors++; $display("FAIL reread_hold: got done_cycle=%0d hold_bad=%0d want %0d and 0",
                         dcyc, hold_err, DONE_B);
    end
    checks++;
    if (out_b !== v2) begin
      errors++; $display("FAIL reread_value: got %h want %h", out_b, v2);
    end
    // Acceptance on the cycle right after FINISH
    val_b = v3;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    checks++;
    if (busy_b !== 1'b1 || read_b !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got busy=%b read=%b want 1 1", busy_b, read_b);
    end
    n = 0; dcyc = -1;
    while (dcyc < 0 && n < DONE_B + 4) begin
      @(posedge clk); #1;
      n++;
      if (done_b) dcyc = n;
    end
    checks++;
    if (dcyc != DONE_B || out_b !== v3) begin
      errors++; $display("FAIL b2b_read: got cycle=%0d out=%h want %0d %h",
                         dcyc, out_b, DONE_B, v3);
    end
  endtask

  initial begin
    logic [63:0] r;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    val_a = '0; val_b = '0;
    test_reset();
    test_auto_read(EXP_A, 1'b0, "auto_match");
    test_auto_read(57'h1A2B3C4D5E6F788, 1'b0, "auto_mismatch");
    r = {$urandom, $urandom};
    test_auto_read(r[WA-1:0], 1'b1, "start_ignored");
    test_reset_mid();
    test_idle_no_auto();
    test_small_read(8'hA5);
    for (int i = 0; i < 4; i++) begin
      r = {32'h0, $urandom};
      repeat ($urandom_range(0, 5)) @(posedge clk);
      @(negedge clk);
      test_small_read(r[7:0]);
    end
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dna_reader.md
# dna_reader

Autonomous controller that reads a device DNA identifier out of a DNA_PORT-style serial primitive and presents it as a parallel word. It sits next to the primitive instance and generates the primitive's clock, READ and SHIFT strobes from the fabric clock. It captures the bits MSB first and can optionally compare the captured word against a build-time expected value. Width, DNA clock rate, auto-start and the compare function are parametrised.

## Interface
Parameters:
- DNA_WIDTH, 57: number of identifier bits captured (≥2).
- CLK_DIV, 2: CLK cycles per DNA_CLK half-period (≥1). DNA_CLK period = 2*CLK_DIV CLK cycles.
- AUTO_START, 1: 1 = start a read automatically on the first CLK edge after reset deasserts.
- CHECK_EN, 0: 1 = drive MATCH from the compare; 0 = MATCH held 0.
- EXPECTED_DNA, {DNA_WIDTH{1'b0}}: value compared against the captured word.

Ports:
- CLK  in  1  fabric clock. One clock domain only.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  pulse that requests a read. Accepted only while not BUSY.
- BUSY  out  1  high from the cycle after acceptance through the final capture.
- DONE  out  1  single-cycle pulse when DNA_OUT becomes valid.
- DNA_VALID  out  1  level. High while DNA_OUT holds a complete read.
- DNA_OUT  out  DNA_WIDTH  captured identifier, MSB = first bit shifted out.
- MATCH  out  1  DNA_OUT == EXPECTED_DNA (only when CHECK_EN = 1). Valid while DNA_VALID is high.
- DNA_CLK  out  1  clock to the primitive CLK pin (register output).
- DNA_READ  out  1  to primitive READ.
- DNA_SHIFT  out  1  to primitive SHIFT.
- DNA_DIN  out  1  to primitive DIN. Tied 0.
- DNA_DOUT  in  1  from primitive DOUT.

## Operation
- States: IDLE, LOAD, SHIFT, FINISH.
- IDLE: DNA_CLK = 0, READ = 0, SHIFT = 0, divider held at 0.
  - Leave IDLE when START = 1, or on the first post-reset cycle if AUTO_START = 1. Call this the acceptance edge, cycle 0.
  - The acceptance edge registers READ = 1, BUSY = 1, DNA_VALID = 0, MATCH = 0, and clears the shift register and divider. State goes to LOAD.
- Divider: counts 0..CLK_DIV-1. At terminal count, DNA_CLK toggles and the divider wraps to 0.
- LOAD: the first DNA_CLK rise loads the primitive. On the following DNA_CLK fall, READ goes to 0, SHIFT goes to 1, and state goes to SHIFT.
- SHIFT: on every CLK edge that drives DNA_CLK high, capture shift_reg <= {shift_reg[DNA_WIDTH-2:0], DNA_DOUT}. The primitive updates DOUT after that edge.
  - A capture counter runs from 0 to DNA_WIDTH-1.
  - The capture edge with counter = DNA_WIDTH-1 moves to FINISH.
- FINISH (one cycle): DNA_CLK <= 0, SHIFT <= 0, BUSY <= 0, DNA_OUT <= shift_reg, DNA_VALID <= 1, DONE <= 1, MATCH <= CHECK_EN & (shift_reg == EXPECTED_DNA). Then go to IDLE.
- DNA_OUT and DNA_VALID hold until the next acceptance or reset.
- START while BUSY: ignored and not queued.
- START in the FINISH cycle: ignored.
- START while DNA_VALID = 1: re-read. DNA_VALID and MATCH drop on the acceptance edge. DNA_OUT keeps its old value until the next FINISH.
- Reset (asserted at any time, including mid-read): all outputs 0 immediately, state = IDLE, partial capture discarded. If AUTO_START = 1, a new read starts after deassert.

## Timing
- Reset values: BUSY = DONE = DNA_VALID = MATCH = DNA_CLK = DNA_READ = DNA_SHIFT = DNA_DIN = 0, DNA_OUT = 0.
- DNA_CLK rises at cycles CLK_DIV*(2k+1), k = 0..DNA_WIDTH.
  - k = 0 is the load edge.
  - k = 1..DNA_WIDTH are capture edges.
- DONE is high, and DNA_VALID rises, at cycle CLK_DIV*(2*DNA_WIDTH+1)+1.
  - Defaults (57, 2): load edge at cycle 2, captures at cycles 6, 10, …, 230, DONE at cycle 231.
- DNA_READ and DNA_SHIFT change only on DNA_CLK falling-edge cycles or at acceptance/FINISH. This gives a half-period of setup to the primitive.
- Back-to-back reads: the next acceptance can occur on the cycle after FINISH.

## Test plan
- Behavioural DNA model loaded with 57'h1A2B3C4D5E6F789, AUTO_START = 1, CLK_DIV = 2. Release reset.
  - Required: DNA_OUT = 57'h1A2B3C4D5E6F789 and DONE high exactly at cycle 231 after the first post-reset edge.
  - Required: exactly 58 DNA_CLK rises.
- AUTO_START = 0, CLK_DIV = 1, DNA_WIDTH = 8, model value 8'hA5, START pulse at cycle 0.
  - Required: captures at cycles 3, 5, …, 17; DONE at cycle 18; DNA_OUT = 8'hA5.
- START pulses every 10 cycles during a read.
  - Required: all are ignored; exactly one DONE; BUSY is continuous.
- Reset asserted at the 20th capture.
  - Required: all outputs 0 in the same cycle.
  - Required: with AUTO_START = 1, a full new read completes with the correct value, and no DONE comes from the aborted read.
- CHECK_EN = 1, EXPECTED_DNA = 57'h1A2B3C4D5E6F789.
  - Required: MATCH = 1. Rerun with model value 57'h1A2B3C4D5E6F788: MATCH = 0.
- START with DNA_VALID = 1.
  - Required: DNA_VALID drops on the next edge and DNA_OUT holds its old value until the new DONE.
